pwm_sample_pacer: RTL and testbench

Rate-regulating sample buffer that sits directly upstream of the PWM output stage. Accepts bursty signed audio/baseband samples over a valid/ready handshake, stores them in a small FIFO, and releases exactly one sample per programmable period as a single-cycle `out_valid` strobe. This matches the PWM stage's `data_valid`/`data` input. Handles start-up priming and underflow so the PWM stage always receives an evenly paced stream.

---
 rtl/pwm_sample_pacer_if.sv | 31 +++
 rtl/pwm_sample_pacer.sv | 111 +++++++++++
 tb/tb_pwm_sample_pacer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_sample_pacer_if.sv
// pwm_sample_pacer_if: sample handshake bundle between upstream source, pacer and PWM stage.
// Rev 1.0
`default_nettype none

interface pwm_sample_pacer_if #(
  parameter int WIDTH = 8
) ();
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_data;
  logic                    out_valid;
  logic signed [WIDTH-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

`default_nettype wire

// File: rtl/pwm_sample_pacer.sv
// pwm_sample_pacer: FIFO that releases one sample per rate_div+1 cycles to the PWM stage.
// Option macro PWM_PACER_HOLD_LAST_EN: underflow repeats the last sample instead of 0. Rev 1.0
`default_nettype none

module pwm_sample_pacer #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int DIV_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   clock_sreset_n,
  pwm_sample_pacer_if.slave      bus,
  input  logic [DIV_WIDTH-1:0]   rate_div,
  output logic [$clog2(DEPTH):0] level,
  output logic                   underflow,
  output logic [15:0]            underflow_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [LW-1:0]        FULL_LEVEL = LW'(DEPTH);
  localparam logic [LW-1:0]        HALF_LEVEL = LW'(DEPTH / 2);
  localparam logic [LW-1:0]        LVL_ONE    = LW'(1);
  localparam logic [AW-1:0]        PTR_ONE    = AW'(1);
  localparam logic [DIV_WIDTH-1:0] CNT_ONE    = DIV_WIDTH'(1);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]              state;
  logic [AW-1:0]           rd_ptr;
  logic [AW-1:0]           wr_ptr;
  logic [DIV_WIDTH-1:0]    cnt;
  logic signed [WIDTH-1:0] mem [DEPTH];

  logic                    tick;
  logic                    push;
  logic                    pop;
  logic signed [WIDTH-1:0] fill_value;

  // Ready is forced low while reset is asserted so nothing is accepted mid-reset.
  assign bus.in_ready = clock_sreset_n && (level != FULL_LEVEL);
  assign push         = bus.in_valid && bus.in_ready;
  assign tick         = (cnt == '0);
  assign pop          = (state == RUN) && tick && (level != '0);

`ifdef PWM_PACER_HOLD_LAST_EN
  assign fill_value = bus.out_data;
`else
  assign fill_value = '0;
`endif

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!clock_sreset_n) begin
      state           <= FILL;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      level           <= '0;
      cnt             <= '0;
      bus.out_valid   <= 1'b0;
      bus.out_data    <= '0;
      underflow       <= 1'b0;
      underflow_count <= '0;
    end else begin
      cnt           <= tick ? rate_div : (cnt - CNT_ONE);
      bus.out_valid <= 1'b0;
      underflow     <= 1'b0;

      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        level <= level + LVL_ONE;
      end else if (pop && !push) begin
        level <= level - LVL_ONE;
      end

      if (state == FILL) begin
        if (level >= HALF_LEVEL) begin
          state <= RUN;
        end
      end else if (tick) begin
        bus.out_valid <= 1'b1;
        if (level != '0) begin
          bus.out_data <= mem[rd_ptr];
        end else begin
          // Empty on a tick: emit the fill value and re-prime before resuming.
          bus.out_data <= fill_value;
          underflow    <= 1'b1;
          state        <= FILL;
          if (underflow_count != 16'hFFFF) begin
            underflow_count <= underflow_count + 16'd1;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pwm_sample_pacer.sv
// tb_pwm_sample_pacer: directed self-checking bench for pwm_sample_pacer.
// Rev 1.0
`default_nettype none

module tb_pwm_sample_pacer;

  localparam int WIDTH     = 8;
  localparam int DEPTH     = 16;
  localparam int DIV_WIDTH = 16;

`ifdef PWM_PACER_HOLD_LAST_EN
  localparam logic [7:0] FILL_EXP = 8'd8;
`else
  localparam logic [7:0] FILL_EXP = 8'd0;
`endif

  logic                 clock = 1'b0;
  logic                 clock_sreset_n = 1'b0;
  logic [DIV_WIDTH-1:0] rate_div = 16'd3;
  logic [4:0]           level;
  logic                 underflow;
  logic [15:0]          underflow_count;

  pwm_sample_pacer_if #(.WIDTH(WIDTH)) bus ();

  pwm_sample_pacer #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .DIV_WIDTH(DIV_WIDTH)
  ) dut (
    .clock          (clock),
    .clock_sreset_n (clock_sreset_n),
    .bus            (bus),
    .rate_div       (rate_div),
    .level          (level),
    .underflow      (underflow),
    .underflow_count(underflow_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rel = 0;

  logic [7:0] mon_data[$];
  bit         mon_uf[$];
  int         mon_cyc[$];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (bus.out_valid) begin
      mon_data.push_back(8'(bus.out_data));
      mon_uf.push_back(underflow);
      mon_cyc.push_back(cyc);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Advance until just after edge n, counting E0 as the first edge after release.
  task automatic go_edge(input int n);
    int lim;
    lim = 0;
    while (cyc < rel + n + 1 && lim < 100000) begin
      step();
      lim++;
    end
  endtask

  task automatic do_reset(input int n);
    clock_sreset_n = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    repeat (n) step();
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_level", level, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", 8'(bus.out_data), 0);
    check("rst_underflow", underflow, 0);
    check("rst_uf_count", underflow_count, 0);
    mon_data.delete();
    mon_uf.delete();
    mon_cyc.delete();
    clock_sreset_n = 1'b1;
    #1;
    check("rel_in_ready", bus.in_ready, 1);
    rel = cyc;
  endtask

  task automatic push_seq(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = WIDTH'(first + i);
      step();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_strobes(input int n, input int limit, input string tag);
    int t;
    t = 0;
    while (mon_data.size() < n && t < limit) begin
      step();
      t++;
    end
    check(tag, 32'(mon_data.size() >= n), 1);
  endtask

  // Prime with 1..8, drain to underflow, then confirm priming is needed again.
  task automatic run_burst(input int rate, input int first_edge);
    int bad;
    do_reset(2);
    rate_div = DIV_WIDTH'(rate);
    push_seq(1, 8);
    go_edge(first_edge - 1);
    check("prime_quiet", mon_data.size(), 0);
    check("prime_level", level, 8);
    go_edge(first_edge);
    check("first_valid", bus.out_valid, 1);
    check("first_data", 8'(bus.out_data), 1);
    go_edge(first_edge + 1);
    check("strobe_width", bus.out_valid, 0);
    check("data_hold", 8'(bus.out_data), 1);
    wait_strobes(9, 40 * (rate + 1), "burst_timeout");
    if (mon_data.size() >= 9) begin
      bad = 0;
      for (int i = 0; i < 8; i++) begin
        if (mon_data[i] != 8'(i + 1) || mon_uf[i]) bad++;
      end
      for (int i = 1; i < 9; i++) begin
        if (mon_cyc[i] - mon_cyc[i-1] != rate + 1) bad++;
      end
      check("burst_seq", bad, 0);
      check("burst_fill", mon_data[8], FILL_EXP);
      check("burst_uf_flag", mon_uf[8], 1);
    end
    check("uf_pulse", underflow, 0);
    check("uf_count", underflow_count, 1);
    check("uf_level", level, 0);
    push_seq(100, 3);
    repeat (4 * (rate + 1)) step();
    check("refill_quiet", mon_data.size(), 9);
    check("refill_level", level, 3);
  endtask

  initial begin
    int k;
    int t;
    int bad;
    bit saw_full;
    int ready_bad;

    // Burst at rate_div 3 (first output at E12) and 9 (first output at E10).
    run_burst(3, 12);
    run_burst(9, 10);

    // Source faster than drain: backpressure, ordering over 1000 samples.
    do_reset(2);
    rate_div  = 16'd3;
    k         = 0;
    t         = 0;
    saw_full  = 1'b0;
    ready_bad = 0;
    while (k < 1000 && t < 8000) begin
      bus.in_valid = 1'b1;
      bus.in_data  = WIDTH'(k);
      #1;
      if (bus.in_ready !== (level != 5'd16)) ready_bad++;
      if (level == 5'd16 && !bus.in_ready) saw_full = 1'b1;
      if (bus.in_ready) k++;
      step();
      t++;
    end
    bus.in_valid = 1'b0;
    wait_strobes(1000, 6000, "stream_timeout");
    bad = 0;
    for (int i = 0; i < 1000 && i < mon_data.size(); i++) begin
      if (mon_data[i] != 8'(i) || mon_uf[i]) bad++;
    end
    check("stream_order", bad, 0);
    check("stream_full_seen", saw_full, 1);
    check("stream_ready", ready_bad, 0);
    check("stream_pushed", k, 1000);

    // rate_div 3 -> 0 mid-period: the running period still lasts 4 cycles.
    do_reset(2);
    rate_div = 16'd3;
    push_seq(1, 12);
    go_edge(12);
    check("rc_first", 8'(bus.out_data), 1);
    go_edge(13);
    rate_div = 16'd0;
    go_edge(15);
    check("rc_hold", bus.out_valid, 0);
    go_edge(16);
    check("rc_valid16", bus.out_valid, 1);
    check("rc_data16", 8'(bus.out_data), 2);
    go_edge(17);
    check("rc_valid17", bus.out_valid, 1);
    check("rc_data17", 8'(bus.out_data), 3);
    wait_strobes(12, 100, "rc_timeout");
    if (mon_data.size() >= 12) begin
      check("rc_gap0", mon_cyc[1] - mon_cyc[0], 4);
      bad = 0;
      for (int i = 2; i < 12; i++) begin
        if (mon_cyc[i] - mon_cyc[i-1] != 1) bad++;
      end
      for (int i = 0; i < 12; i++) begin
        if (mon_data[i] != 8'(i + 1)) bad++;
      end
      check("rc_seq", bad, 0);
    end

    // Push coinciding with a pop at level 5.
    do_reset(2);
    rate_div = 16'd3;
    push_seq(1, 8);
    go_edge(23);
    check("pp_level_before", level, 5);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    go_edge(24);
    bus.in_valid = 1'b0;
    check("pp_level_after", level, 5);
    check("pp_pop_data", 8'(bus.out_data), 4);
    wait_strobes(9, 100, "pp_timeout");
    if (mon_data.size() >= 9) begin
      check("pp_next", mon_data[4], 5);
      check("pp_last_old", mon_data[7], 8);
      check("pp_new", mon_data[8], 8'h55);
    end

    // One-cycle reset while running at level 12.
    do_reset(2);
    rate_div = 16'd3;
    push_seq(1, 16);
    go_edge(24);
    check("mr_level", level, 12);
    check("mr_data", 8'(bus.out_data), 4);
    do_reset(1);
    push_seq(1, 8);
    go_edge(11);
    check("mr_reprime_quiet", mon_data.size(), 0);
    go_edge(12);
    check("mr_reprime_data", 8'(bus.out_data), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
